// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial transmit/receive blocks.
package serial_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam logic IDLE_BIT  = 1'b0;
  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

endpackage

// File: rtl/serial_shreg.sv
// Loadable right-shift register; the LSB is the next bit to go out on the line.
module serial_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             shift,
  output logic             lsb
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= data;
    end else if (shift) begin
      sr <= {1'b0, sr[WIDTH-1:1]};
    end
  end

  assign lsb = sr[0];

endmodule

// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start, WIDTH data bits LSB first,
// optional parity, stop. Accepts a word over valid/ready in IDLE or STOP.
//
// state  | meaning
// IDLE   | line at 0, waiting for a word
// START  | start bit (1) on the line
// DATA   | data bit cnt on the line
// PARITY | parity bit on the line
// STOP   | stop bit (0) on the line; next word may be accepted
module serial_tx
  import serial_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic          ODD    = (PARITY_ODD != 0);
  localparam logic          HAS_PB = (PARITY_EN != 0);

  tx_state_t     ps;
  logic [CW-1:0] cnt;
  logic          par;
  logic          accept;
  logic          shift;
  logic          sr_lsb;

  assign ready  = ((ps == IDLE) || (ps == STOP)) && !reset;
  assign accept = valid && ready;
  // Each START/DATA edge moves the register's LSB onto the line, so shift then.
  assign shift  = (ps == START) || (ps == DATA);

  serial_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .data  (data),
    .shift (shift),
    .lsb   (sr_lsb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps   <= IDLE;
      cnt  <= '0;
      par  <= 1'b0;
      out  <= IDLE_BIT;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (ps)
        IDLE, STOP: begin
          if (accept) begin
            ps   <= START;
            out  <= START_BIT;
            busy <= 1'b1;
            done <= 1'b0;
            par  <= (^data) ^ ODD;
          end else begin
            ps   <= IDLE;
            out  <= IDLE_BIT;
            busy <= 1'b0;
            done <= 1'b0;
          end
        end
        START: begin
          ps  <= DATA;
          cnt <= '0;
          out <= sr_lsb;
        end
        DATA: begin
          if (cnt == LAST) begin
            if (HAS_PB) begin
              ps  <= PARITY;
              out <= par;
            end else begin
              ps   <= STOP;
              out  <= STOP_BIT;
              done <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
            out <= sr_lsb;
          end
        end
        PARITY: begin
          ps   <= STOP;
          out  <= STOP_BIT;
          done <= 1'b1;
        end
        default: begin
          ps   <= IDLE;
          out  <= IDLE_BIT;
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule
